// File: rtl/snow_pkg.sv
// Shared constants, FSM state type and per-layer seed helper for the
// multi-layer snowfall generator.
package snow_pkg;

    localparam int          LFSR_W    = 16;
    localparam logic [15:0] LFSR_TAPS = 16'hD008;
    localparam logic [15:0] SEED_BASE = 16'hACE1;

    typedef enum logic [1:0] {
        INIT,
        WAIT_FRAME,
        RUN
    } state_e;

    // XOR with a small layer index keeps every seed distinct and non-zero.
    function automatic logic [LFSR_W-1:0] layer_seed(input int unsigned k);
        return SEED_BASE ^ LFSR_W'(k);
    endfunction

endpackage

// File: rtl/snow_lfsr.sv
// 16-bit right-shifting Galois LFSR with step enable; exposes its low bits as
// the random value used for the density compare.
module snow_lfsr
    import snow_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED  = SEED_BASE,
    parameter int                OUT_W = 8
) (
    input  logic             clk_pix,
    input  logic             rst_pix_n,
    input  logic             en_i,
    output logic [OUT_W-1:0] rnd_o
);

    logic [LFSR_W-1:0] state_q, state_d;

    // NOTE: state_d gets its default before any branch, so no latch is inferred.
    always_comb begin
        state_d = state_q;
        if (en_i) begin
            state_d = (state_q >> 1) ^ (state_q[0] ? LFSR_TAPS : '0);
        end
    end

    // NOTE: sequential state is updated with non-blocking assignments only.
    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q <= SEED;
        end else begin
            state_q <= state_d;
        end
    end

    assign rnd_o = state_q[OUT_W-1:0];

endmodule

// File: rtl/snow_layers.sv
// Multi-layer scrolling snowfall bitmap: fills a GRID_W x GRID_H RAM from
// per-layer LFSRs, scrolls layer k every 2^k frames and regenerates the top row.
module snow_layers
    import snow_pkg::*;
#(
    parameter int N_LAYERS = 3,
    parameter int CORDW    = 10,
    parameter int GRID_W   = 256,
    parameter int GRID_H   = 256,
    parameter int DENS_W   = 8
) (
    input  logic                       clk_pix,
    input  logic                       rst_pix_n,
    input  logic [CORDW-1:0]           sx,
    input  logic [CORDW-1:0]           sy,
    input  logic                       de,
    input  logic                       frame_start,
    input  logic [N_LAYERS-1:0]        layer_en,
    input  logic [N_LAYERS*DENS_W-1:0] density,
    output logic                       ready,
    output logic [N_LAYERS-1:0]        snow,
    output logic                       snow_any
);

    localparam int COL_W  = $clog2(GRID_W);
    localparam int ROW_W  = $clog2(GRID_H);
    localparam int ADDR_W = ROW_W + COL_W;
    localparam int DEPTH  = GRID_W * GRID_H;
    localparam int FCNT_W = (N_LAYERS > 1) ? N_LAYERS - 1 : 1;
    localparam logic [CORDW:0] GRID_W_C = GRID_W[CORDW:0];
    localparam logic [CORDW:0] GRID_H_C = GRID_H[CORDW:0];

    state_e                          state_q;
    logic [ADDR_W-1:0]               init_addr_q;
    logic [N_LAYERS-1:0][FCNT_W-1:0] fcnt_q, fcnt_d;
    logic [N_LAYERS-1:0][ROW_W-1:0]  offset_q, offset_d;
    logic [N_LAYERS-1:0]             regen_q, regen_d;
    logic [N_LAYERS-1:0][DENS_W-1:0] rnd;
    logic [N_LAYERS-1:0]             fresh, we_d;
    logic [N_LAYERS-1:0][ROW_W-1:0]  wrow, rrow;
    logic [N_LAYERS-1:0][ADDR_W-1:0] waddr_d, waddr_q, raddr_d, raddr_q;
    logic [N_LAYERS-1:0]             rvalid_d, rvalid_q, we_q, wbit_q;
    logic [N_LAYERS-1:0]             rbit, snow_d, snow_q;
    logic                            snow_any_q;
    logic [N_LAYERS-1:0]             mem_q [DEPTH];
    logic [COL_W-1:0]                col;
    logic                            in_grid, running, frame_tick;

    assign col        = sx[COL_W-1:0];
    assign in_grid    = de && ({1'b0, sx} < GRID_W_C) && ({1'b0, sy} < GRID_H_C);
    // ready must rise in the very frame_start cycle that leaves WAIT_FRAME.
    assign running    = (state_q == RUN) || ((state_q == WAIT_FRAME) && frame_start);
    assign frame_tick = (state_q == RUN) && frame_start;

    for (genvar k = 0; k < N_LAYERS; k++) begin : g_lfsr
        snow_lfsr #(
            .SEED  (layer_seed(k)),
            .OUT_W (DENS_W)
        ) u_lfsr (
            .clk_pix   (clk_pix),
            .rst_pix_n (rst_pix_n),
            .en_i      (we_d[k]),
            .rnd_o     (rnd[k])
        );
    end

    // offset_d/regen_d are the values in force for the current pixel, so the
    // frame_start pixel already uses this frame's scroll and regen state.
    always_comb begin
        fcnt_d   = fcnt_q;
        offset_d = offset_q;
        regen_d  = regen_q;
        fresh    = '0;
        we_d     = '0;
        wrow     = '0;
        rrow     = '0;
        waddr_d  = '0;
        raddr_d  = '0;
        rvalid_d = '0;
        for (int k = 0; k < N_LAYERS; k++) begin
            fresh[k] = rnd[k] < density[k*DENS_W +: DENS_W];
            if (frame_tick) begin
                fcnt_d[k]  = (fcnt_q[k] + 1'b1) & FCNT_W'((1 << k) - 1);
                regen_d[k] = (fcnt_d[k] == '0);
                if (regen_d[k]) begin
                    offset_d[k] = offset_q[k] + 1'b1;
                end
            end
            wrow[k] = '0 - offset_d[k];
            rrow[k] = sy[ROW_W-1:0] - offset_d[k];
            if (state_q == INIT) begin
                we_d[k]    = 1'b1;
                waddr_d[k] = init_addr_q;
            end else if (regen_d[k] && (sy == '0) && in_grid) begin
                we_d[k]    = 1'b1;
                waddr_d[k] = {wrow[k], col};
            end
            raddr_d[k]  = {rrow[k], col};
            rvalid_d[k] = running && in_grid && layer_en[k];
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            state_q     <= INIT;
            init_addr_q <= '0;
        end else begin
            case (state_q)
                INIT: begin
                    init_addr_q <= init_addr_q + 1'b1;
                    if (init_addr_q == ADDR_W'(DEPTH - 1)) begin
                        state_q <= WAIT_FRAME;
                    end
                end
                WAIT_FRAME: begin
                    if (frame_start) begin
                        state_q <= RUN;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_pix or negedge rst_pix_n) begin
        if (!rst_pix_n) begin
            fcnt_q     <= '0;
            offset_q   <= '0;
            regen_q    <= '0;
            we_q       <= '0;
            wbit_q     <= '0;
            waddr_q    <= '0;
            raddr_q    <= '0;
            rvalid_q   <= '0;
            snow_q     <= '0;
            snow_any_q <= 1'b0;
        end else begin
            fcnt_q     <= fcnt_d;
            offset_q   <= offset_d;
            regen_q    <= regen_d;
            we_q       <= we_d;
            wbit_q     <= fresh;
            waddr_q    <= waddr_d;
            raddr_q    <= raddr_d;
            rvalid_q   <= rvalid_d;
            snow_q     <= snow_d;
            snow_any_q <= |snow_d;
        end
    end

    // NOTE: the RAM has no reset; INIT rewrites every word before any read.
    always_ff @(posedge clk_pix) begin
        for (int k = 0; k < N_LAYERS; k++) begin
            if (we_q[k]) begin
                mem_q[waddr_q[k]][k] <= wbit_q[k];
            end
        end
    end

    // Write-first: a bit being written this cycle wins over the stored word.
    always_comb begin
        rbit = '0;
        for (int k = 0; k < N_LAYERS; k++) begin
            rbit[k] = (we_q[k] && (waddr_q[k] == raddr_q[k])) ? wbit_q[k]
                                                               : mem_q[raddr_q[k]][k];
        end
    end

    assign snow_d   = rvalid_q & rbit;
    assign ready    = running;
    assign snow     = snow_q;
    assign snow_any = snow_any_q;

endmodule

// File: tb/tb_snow_layers.sv
// Directed bench for snow_layers on an 8x4 grid inside a 12x6 screen, with a
// behavioural model of fill, scroll, regeneration and the 2-cycle output delay.
module tb_snow_layers;

    localparam int N_LAYERS = 3;
    localparam int CORDW    = 10;
    localparam int GRID_W   = 8;
    localparam int GRID_H   = 4;
    localparam int DENS_W   = 8;
    localparam int SCR_W    = 12;
    localparam int SCR_H    = 6;

    logic                       clk_pix = 1'b0;
    logic                       rst_pix_n = 1'b0;
    logic [CORDW-1:0]           sx = '0;
    logic [CORDW-1:0]           sy = '0;
    logic                       de = 1'b0;
    logic                       frame_start = 1'b0;
    logic [N_LAYERS-1:0]        layer_en = '1;
    logic [N_LAYERS*DENS_W-1:0] density = '0;
    logic                       ready;
    logic [N_LAYERS-1:0]        snow;
    logic                       snow_any;

    always #5 clk_pix = ~clk_pix;

    snow_layers #(
        .N_LAYERS (N_LAYERS),
        .CORDW    (CORDW),
        .GRID_W   (GRID_W),
        .GRID_H   (GRID_H),
        .DENS_W   (DENS_W)
    ) dut (
        .clk_pix     (clk_pix),
        .rst_pix_n   (rst_pix_n),
        .sx          (sx),
        .sy          (sy),
        .de          (de),
        .frame_start (frame_start),
        .layer_en    (layer_en),
        .density     (density),
        .ready       (ready),
        .snow        (snow),
        .snow_any    (snow_any)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Hand-derived scroll offsets per RUN frame (frame 0 is the one entered from WAIT_FRAME).
    int off_tab [8][3] = '{'{0, 0, 0}, '{1, 0, 0}, '{2, 1, 0}, '{3, 1, 0},
                           '{0, 2, 1}, '{1, 2, 1}, '{2, 3, 1}, '{3, 3, 1}};

    typedef enum {M_INIT, M_WAIT, M_RUN} mstate_e;
    mstate_e             m_state;
    int                  m_addr;
    logic [15:0]         m_lfsr [N_LAYERS];
    logic [N_LAYERS-1:0] m_mem [GRID_H][GRID_W];
    int                  m_fcnt [N_LAYERS];
    int                  m_off [N_LAYERS];
    bit                  m_regen [N_LAYERS];
    logic [N_LAYERS-1:0] exp_q [$];
    bit                  got_ready;
    int                  low_cycles;

    function automatic logic [15:0] galois(input logic [15:0] s);
        return s[0] ? ((s >> 1) ^ 16'hD008) : (s >> 1);
    endfunction

    function automatic bit fresh_bit(input int k);
        bit b;
        b = m_lfsr[k][7:0] < density[k*DENS_W +: DENS_W];
        m_lfsr[k] = galois(m_lfsr[k]);
        return b;
    endfunction

    function automatic void model_reset();
        m_state = M_INIT;
        m_addr  = 0;
        for (int k = 0; k < N_LAYERS; k++) begin
            m_lfsr[k]  = 16'hACE1 ^ 16'(k);
            m_fcnt[k]  = 0;
            m_off[k]   = 0;
            m_regen[k] = 1'b0;
        end
    endfunction

    task automatic model_pixel(input int x, input int y, input bit d, input bit fs,
                               output logic [N_LAYERS-1:0] e_snow, output logic e_ready);
        bit in_grid;
        bit run_now;
        in_grid = d && (x < GRID_W) && (y < GRID_H);
        e_snow  = '0;
        e_ready = 1'b0;
        if (m_state == M_INIT) begin
            for (int k = 0; k < N_LAYERS; k++) begin
                m_mem[m_addr / GRID_W][m_addr % GRID_W][k] = fresh_bit(k);
            end
            m_addr++;
            if (m_addr == GRID_W * GRID_H) m_state = M_WAIT;
        end else begin
            run_now = (m_state == M_RUN) || fs;
            if (m_state == M_RUN && fs) begin
                for (int k = 0; k < N_LAYERS; k++) begin
                    m_fcnt[k]  = (m_fcnt[k] + 1) % (1 << k);
                    m_regen[k] = (m_fcnt[k] == 0);
                    if (m_regen[k]) m_off[k] = (m_off[k] + 1) % GRID_H;
                end
            end
            if (m_state == M_WAIT && fs) m_state = M_RUN;
            if (run_now) begin
                e_ready = 1'b1;
                for (int k = 0; k < N_LAYERS; k++) begin
                    if (m_regen[k] && y == 0 && in_grid)
                        m_mem[(GRID_H - m_off[k]) % GRID_H][x][k] = fresh_bit(k);
                    if (in_grid && layer_en[k])
                        e_snow[k] = m_mem[(y - m_off[k] + GRID_H) % GRID_H][x][k];
                end
            end
        end
    endtask

    // One pixel per clock; outputs compared two pixels later, away from the edge.
    task automatic step(input int x, input int y, input bit d, input bit fs);
        logic [N_LAYERS-1:0] e_snow;
        logic [N_LAYERS-1:0] want;
        logic                e_ready;
        sx          = CORDW'(x);
        sy          = CORDW'(y);
        de          = d;
        frame_start = fs;
        model_pixel(x, y, d, fs, e_snow, e_ready);
        #1;
        check("ready", 32'(ready), 32'(e_ready));
        if (!got_ready) begin
            if (ready) got_ready = 1'b1;
            else       low_cycles++;
        end
        exp_q.push_back(e_snow);
        @(posedge clk_pix);
        #1;
        if (exp_q.size() >= 2) begin
            want = exp_q.pop_front();
            check("snow", 32'(snow), 32'(want));
            check("snow_any", 32'(snow_any), 32'(|want));
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(SCR_W - 1, SCR_H - 1, 1'b0, 1'b0);
    endtask

    task automatic frame(input bit de_hole);
        for (int y = 0; y < SCR_H; y++) begin
            for (int x = 0; x < SCR_W; x++) begin
                step(x, y, !(de_hole && x == 2 && y == 1), (x == 0 && y == 0));
            end
        end
    endtask

    task automatic check_lfsrs();
        check("lfsr0", 32'(dut.g_lfsr[0].u_lfsr.state_q), 32'(m_lfsr[0]));
        check("lfsr1", 32'(dut.g_lfsr[1].u_lfsr.state_q), 32'(m_lfsr[1]));
        check("lfsr2", 32'(dut.g_lfsr[2].u_lfsr.state_q), 32'(m_lfsr[2]));
    endtask

    task automatic check_offsets(input int f);
        for (int k = 0; k < N_LAYERS; k++) begin
            check($sformatf("offset%0d_f%0d", k, f), 32'(dut.offset_q[k]), 32'(off_tab[f][k]));
        end
    endtask

    // Asynchronous assertion: outputs must clear before any clock edge.
    task automatic do_reset();
        rst_pix_n = 1'b0;
        model_reset();
        exp_q.delete();
        #1;
        check("rst_ready", 32'(ready), 32'd0);
        check("rst_snow", 32'(snow), 32'd0);
        check("rst_snow_any", 32'(snow_any), 32'd0);
        check("rst_init_addr", 32'(dut.init_addr_q), 32'd0);
        @(posedge clk_pix);
        #1;
        rst_pix_n  = 1'b1;
        got_ready  = 1'b0;
        low_cycles = 0;
    endtask

    // Fill takes 32 cycles; the frame_start landing on the last fill cycle is
    // ignored, so ready first rises one 72-cycle frame later (31 + 72 low cycles).
    task automatic fill_and_start();
        idle(31);
        frame(1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        n_errors++;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $fatal(1, "watchdog");
    end

    initial begin
        model_reset();
        do_reset();

        // Density 0 everywhere, with a reset landing on fill address 17.
        density  = {3{8'd0}};
        layer_en = 3'b111;
        idle(17);
        do_reset();
        fill_and_start();
        for (int f = 0; f < 8; f++) begin
            frame(1'b0);
            if (f == 0) check("ready_latency", 32'(low_cycles), 32'd103);
            check_offsets(f);
            check_lfsrs();
        end

        // Mixed densities: scrolling, regeneration with bypass, masking, de holes.
        density  = {8'd60, 8'd128, 8'd200};
        layer_en = 3'b111;
        do_reset();
        fill_and_start();
        for (int f = 0; f < 5; f++) begin
            frame(1'b0);
            if (f == 0) check("ready_latency_b", 32'(low_cycles), 32'd103);
            check_offsets(f);
            check_lfsrs();
        end
        layer_en = 3'b101;
        frame(1'b1);
        check_lfsrs();
        layer_en = 3'b111;
        density  = {3{8'd128}};
        frame(1'b1);
        check_lfsrs();

        // Saturated density, then a reset in the middle of a RUN frame.
        density = {3{8'd255}};
        for (int f = 0; f < 3; f++) begin
            frame(1'b0);
            check_lfsrs();
        end
        for (int i = 0; i < 30; i++) step(i % SCR_W, i / SCR_W, 1'b1, (i == 0));
        do_reset();
        idle(4);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
